// File: rtl/indexed_shift_pkg.sv
// Shared definitions for the indexed shift-array family (extract and insert sides).
// Holds the default geometry and the request/response FSM encoding.
package indexed_shift_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MAX_ELEMENTS = 16;
  localparam int DEF_IDX_WIDTH    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/indexed_lsh_mod.sv
// One array position of the left-shift network: entries at or above the
// extracted index take their upper neighbour, entries below keep their value.
module indexed_lsh_mod
  import indexed_shift_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int POS        = 0
) (
  input  logic [DATA_WIDTH-1:0] cur_i,
  input  logic [DATA_WIDTH-1:0] nxt_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  output logic [DATA_WIDTH-1:0] out_o
);

  localparam logic [IDX_WIDTH-1:0] POS_C = IDX_WIDTH'(POS);

  assign out_o = (idx_i <= POS_C) ? nxt_i : cur_i;

endmodule

// File: rtl/indexed_lsh_extract.sv
// Flip-flop array with indexed extract: the selected entry is returned and
// everything above it shifts down one slot, zero-filling the top.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; load and request are taken only in IDLE, load has priority over request,
// and a response stays stable from the cycle after acceptance until rsp_ready.
module indexed_lsh_extract
  import indexed_shift_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MAX_ELEMENTS = DEF_MAX_ELEMENTS,
  parameter int IDX_WIDTH    = DEF_IDX_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_valid,
  input  logic [DATA_WIDTH*MAX_ELEMENTS-1:0] load_arr,
  input  logic [IDX_WIDTH:0]                 load_count,
  output logic                               load_ready,
  input  logic                               req_valid,
  input  logic [IDX_WIDTH-1:0]               req_idx,
  output logic                               req_ready,
  output logic                               rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               rsp_err,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH*MAX_ELEMENTS-1:0] arr_out,
  output logic [IDX_WIDTH:0]                 count,
  output logic                               empty
);

  localparam logic [IDX_WIDTH:0] MAX_CNT = (IDX_WIDTH+1)'(MAX_ELEMENTS);
  localparam logic [IDX_WIDTH:0] ONE_CNT = (IDX_WIDTH+1)'(1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   arr_q [MAX_ELEMENTS];
  logic [IDX_WIDTH:0]      count_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_err_q;

  logic [DATA_WIDTH-1:0]   shift_c [MAX_ELEMENTS];
  logic [DATA_WIDTH-1:0]   load_c  [MAX_ELEMENTS];
  logic [IDX_WIDTH:0]      load_cnt_c;
  logic                    req_hit_c;
  logic                    idle_c;

  assign idle_c     = (state_q == ST_IDLE);
  assign load_ready = idle_c;
  assign req_ready  = idle_c && !load_valid;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);

  // Oversized loads saturate at capacity rather than wrapping.
  assign load_cnt_c = (load_count > MAX_CNT) ? MAX_CNT : load_count;
  assign req_hit_c  = ({1'b0, req_idx} < count_q);

  for (genvar i = 0; i < MAX_ELEMENTS; i++) begin : g_elem
    logic [DATA_WIDTH-1:0] nxt;

    if (i == MAX_ELEMENTS - 1) begin : g_last
      assign nxt = '0;
    end else begin : g_mid
      assign nxt = arr_q[i+1];
    end

    indexed_lsh_mod #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH),
      .POS        (i)
    ) u_lsh (
      .cur_i (arr_q[i]),
      .nxt_i (nxt),
      .idx_i (req_idx),
      .out_o (shift_c[i])
    );

    assign load_c[i] = ((IDX_WIDTH+1)'(i) < load_cnt_c) ?
                       load_arr[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign arr_out[i*DATA_WIDTH +: DATA_WIDTH] = arr_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      for (int i = 0; i < MAX_ELEMENTS; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            count_q <= load_cnt_c;
            for (int i = 0; i < MAX_ELEMENTS; i++) begin
              arr_q[i] <= load_c[i];
            end
          end else if (req_valid) begin
            state_q <= ST_RESP;
            if (req_hit_c) begin
              rsp_data_q <= arr_q[req_idx];
              rsp_err_q  <= 1'b0;
              count_q    <= count_q - ONE_CNT;
              for (int i = 0; i < MAX_ELEMENTS; i++) begin
                arr_q[i] <= shift_c[i];
              end
            end else begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_indexed_lsh_extract.sv
// Bench for indexed_lsh_extract: directed scenarios plus random load/extract
// traffic, checked against a queue-based model of the valid entries.
module tb_indexed_lsh_extract;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int AW = DW * N;
  localparam int EW = 1 + DW + AW + IW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [AW-1:0] load_arr;
  logic [IW:0]   load_count;
  logic          load_ready;
  logic          req_valid;
  logic [IW-1:0] req_idx;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_ready;
  logic [AW-1:0] arr_out;
  logic [IW:0]   count;
  logic          empty;

  indexed_lsh_extract #(.DATA_WIDTH(DW), .MAX_ELEMENTS(N), .IDX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_arr   (load_arr),
    .load_count (load_count),
    .load_ready (load_ready),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .arr_out    (arr_out),
    .count      (count),
    .empty      (empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] pack_model();
    logic [AW-1:0] r = '0;
    for (int i = 0; i < m_q.size(); i++) r[i*DW +: DW] = m_q[i];
    return r;
  endfunction

  task automatic model_load(input logic [AW-1:0] arr, input logic [IW:0] cnt);
    int n = (int'(cnt) > N) ? N : int'(cnt);
    m_q.delete();
    for (int i = 0; i < n; i++) m_q.push_back(arr[i*DW +: DW]);
  endtask

  task automatic model_extract(input logic [IW-1:0] idx);
    logic [DW-1:0] d;
    logic          err;
    if (int'(idx) < m_q.size()) begin
      d = m_q[idx];
      m_q.delete(int'(idx));
      err = 1'b0;
    end else begin
      d = '0;
      err = 1'b1;
    end
    exp_q.push_back({err, d, pack_model(), (IW+1)'(m_q.size())});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [AW-1:0] arr, input logic [IW:0] cnt);
    wait_idle();
    load_valid = 1'b1;
    load_arr   = arr;
    load_count = cnt;
    model_load(arr, cnt);
    @(negedge clk);
    load_valid = 1'b0;
    check("load_count", count, m_q.size());
    check("load_arr", arr_out, pack_model());
  endtask

  task automatic do_extract(input logic [IW-1:0] idx, input int delay);
    wait_idle();
    req_valid = 1'b1;
    req_idx   = idx;
    rsp_ready = 1'b0;
    model_extract(idx);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_latency", rsp_valid, 1);
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid && rsp_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err",   rsp_err,  e[EW-1]);
          check("rsp_data",  rsp_data, e[EW-2 -: DW]);
          check("rsp_arr",   arr_out,  e[AW+IW : IW+1]);
          check("rsp_count", count,    e[IW:0]);
          check("rsp_empty", empty,    e[IW:0] == '0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] arr;
    logic [EW-1:0] e;

    rst = 1'b1; load_valid = 1'b0; load_arr = '0; load_count = '0;
    req_valid = 1'b0; req_idx = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_load_ready", load_ready, 1);
    check("reset_req_ready",  req_ready,  1);
    check("reset_empty",      empty,      1);
    check("reset_arr",        arr_out,    0);
    check("reset_count",      count,      0);
    check("reset_rsp_valid",  rsp_valid,  0);

    // {10,20,30,40} with junk above count that must be masked
    for (int i = 0; i < N; i++) arr[i*DW +: DW] = (i < 4) ? DW'(10 * (i + 1)) : DW'(32'hdead0000 + i);
    do_load(arr, 5'd4);
    do_extract(4'd1, 0);
    do_extract(4'd3, 1);

    // full array 0..15: extract last then first
    for (int i = 0; i < N; i++) arr[i*DW +: DW] = DW'(i);
    do_load(arr, 5'd16);
    do_extract(4'd15, 0);
    do_extract(4'd0, 0);

    // stalled consumer: response holds, new requests ignored
    wait_idle();
    req_valid = 1'b1; req_idx = 4'd2; rsp_ready = 1'b0;
    model_extract(4'd2);
    e = exp_q[exp_q.size()-1];
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_latency", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data",  rsp_data,  e[EW-2 -: DW]);
      check("hold_req_ready", req_ready, 0);
      req_valid = 1'b1;
      req_idx   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("release_req_ready", req_ready, 1);
    check("release_rsp_valid", rsp_valid, 0);
    check("release_count",     count,     m_q.size());

    // load and request collide: load wins, count saturates
    wait_idle();
    for (int i = 0; i < N; i++) arr[i*DW +: DW] = $urandom;
    load_valid = 1'b1; load_arr = arr; load_count = 5'd20;
    req_valid = 1'b1; req_idx = 4'd0;
    #1;
    check("collide_req_ready", req_ready, 0);
    model_load(arr, 5'd20);
    @(negedge clk);
    load_valid = 1'b0; req_valid = 1'b0;
    check("collide_no_rsp", rsp_valid, 0);
    check("collide_count",  count,     16);
    check("collide_arr",    arr_out,   pack_model());
    @(negedge clk);
    check("collide_no_rsp_later", rsp_valid, 0);

    // reset while a response is pending
    wait_idle();
    req_valid = 1'b1; req_idx = 4'd5; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_reset_rsp_valid", rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_count",     count,     0);
    check("rst_empty",     empty,     1);
    check("rst_arr",       arr_out,   0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_data",  rsp_data,  0);
    rst = 1'b0;
    m_q.delete();

    // random traffic
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N; i++) arr[i*DW +: DW] = $urandom;
        do_load(arr, 5'($urandom_range(0, 20)));
      end else begin
        do_extract(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
